rob_commit_ctrl: RTL and testbench

//  In-order retirement controller (reorder buffer) for the single-issue OoO core.

---
 rtl/rob_commit_ctrl.sv | 104 ++++++++++
 tb/tb_rob_commit_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_ctrl.sv
// In-order retirement ROB: allocates tags at dispatch, captures CDB results by tag, retires the head.
// Commit is combinational from a done head (CDB in N -> commit in N+1); disp_ready drops only when full.
module rob_commit_ctrl #(
  parameter int ROB_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic                 disp_regf_we,
  input  logic [4:0]           disp_rd_s,
  output logic [ROB_DEPTH-1:0] disp_rob,
  input  logic                 cdb_valid,
  input  logic [ROB_DEPTH-1:0] cdb_rob,
  input  logic [31:0]          cdb_rd_v,
  output logic                 commit_valid,
  output logic                 commit_regf_we,
  output logic [4:0]           commit_rd_s,
  output logic [31:0]          commit_rd_v,
  output logic [ROB_DEPTH-1:0] commit_rob,
  output logic                 rob_full,
  output logic                 rob_empty,
  output logic [ROB_DEPTH:0]   rob_count
);

  localparam int NUM_ENTRIES = 1 << ROB_DEPTH;
  localparam logic [ROB_DEPTH:0] PTR_ONE = {{ROB_DEPTH{1'b0}}, 1'b1};

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        regf_we;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
  } rob_entry_t;

  rob_entry_t entries [NUM_ENTRIES];

  logic [ROB_DEPTH:0]   head_ptr;
  logic [ROB_DEPTH:0]   tail_ptr;
  logic [ROB_DEPTH-1:0] head_idx;
  logic [ROB_DEPTH-1:0] tail_idx;
  rob_entry_t           head_entry;
  logic                 disp_fire;
  logic                 cdb_fire;

  assign head_idx   = head_ptr[ROB_DEPTH-1:0];
  assign tail_idx   = tail_ptr[ROB_DEPTH-1:0];
  assign head_entry = entries[head_idx];

  // Wrap bit distinguishes full (same index, different lap) from empty.
  assign rob_empty  = (head_ptr == tail_ptr);
  assign rob_full   = (head_idx == tail_idx) && (head_ptr[ROB_DEPTH] != tail_ptr[ROB_DEPTH]);
  assign rob_count  = tail_ptr - head_ptr;

  assign disp_ready = !rob_full;
  assign disp_rob   = tail_idx;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign cdb_fire   = cdb_valid && entries[cdb_rob].valid && !flush;

  assign commit_valid   = head_entry.valid && head_entry.done && !flush;
  assign commit_regf_we = commit_valid && head_entry.regf_we && (head_entry.rd_s != 5'd0);
  assign commit_rd_s    = head_entry.rd_s;
  assign commit_rd_v    = head_entry.rd_v;
  assign commit_rob     = head_idx;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (disp_fire)    tail_ptr <= tail_ptr + PTR_ONE;
      if (commit_valid) head_ptr <= head_ptr + PTR_ONE;
    end
  end

  // Dispatch and commit never touch the same slot (that needs full or empty), so ordering is free
  // except that retirement must win over a repeat CDB to the committing head.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].done  <= 1'b0;
      end
    end else begin
      if (cdb_fire) begin
        entries[cdb_rob].done <= 1'b1;
        entries[cdb_rob].rd_v <= cdb_rd_v;
      end
      if (commit_valid) begin
        entries[head_idx].valid <= 1'b0;
        entries[head_idx].done  <= 1'b0;
      end
      if (disp_fire) begin
        entries[tail_idx].valid   <= 1'b1;
        entries[tail_idx].done    <= 1'b0;
        entries[tail_idx].regf_we <= disp_regf_we;
        entries[tail_idx].rd_s    <= disp_rd_s;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: one task per scenario, inline comparisons, one summary line.
module tb_rob_commit_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic        disp_regf_we;
  logic [4:0]  disp_rd_s;
  logic [3:0]  disp_rob;
  logic        cdb_valid;
  logic [3:0]  cdb_rob;
  logic [31:0] cdb_rd_v;
  logic        commit_valid;
  logic        commit_regf_we;
  logic [4:0]  commit_rd_s;
  logic [31:0] commit_rd_v;
  logic [3:0]  commit_rob;
  logic        rob_full;
  logic        rob_empty;
  logic [4:0]  rob_count;

  int n_cmp = 0;
  int n_err = 0;

  rob_commit_ctrl #(.ROB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_regf_we(disp_regf_we),
    .disp_rd_s(disp_rd_s), .disp_rob(disp_rob),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_rd_v(cdb_rd_v),
    .commit_valid(commit_valid), .commit_regf_we(commit_regf_we), .commit_rd_s(commit_rd_s),
    .commit_rd_v(commit_rd_v), .commit_rob(commit_rob),
    .rob_full(rob_full), .rob_empty(rob_empty), .rob_count(rob_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush = 0; disp_valid = 0; disp_regf_we = 0; disp_rd_s = 0;
    cdb_valid = 0; cdb_rob = 0; cdb_rd_v = 0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic disp(input logic we, input logic [4:0] rd);
    clr();
    disp_valid = 1; disp_regf_we = we; disp_rd_s = rd;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL rst_disp_ready got %0b want 1", disp_ready); end
    n_cmp++; if (rob_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %0b want 1", rob_empty); end
    n_cmp++; if (rob_full !== 1'b0) begin n_err++; $display("FAIL rst_full got %0b want 0", rob_full); end
    n_cmp++; if (rob_count !== 5'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", rob_count); end
    n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL rst_commit_valid got %0b want 0", commit_valid); end
    n_cmp++; if (commit_regf_we !== 1'b0) begin n_err++; $display("FAIL rst_commit_we got %0b want 0", commit_regf_we); end
    n_cmp++; if (disp_rob !== 4'd0) begin n_err++; $display("FAIL rst_disp_rob got %0d want 0", disp_rob); end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    disp(1, 5'd5);
    @(negedge clk);
    n_cmp++; if (disp_rob !== 4'd0) begin n_err++; $display("FAIL single_tag got %0d want 0", disp_rob); end
    tick();
    clr(); cdb_valid = 1; cdb_rob = 0; cdb_rd_v = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL single_cdb_cycle got %0b want 0", commit_valid); end
    tick();
    clr();
    @(negedge clk);
    n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL single_cv got %0b want 1", commit_valid); end
    n_cmp++; if (commit_regf_we !== 1'b1) begin n_err++; $display("FAIL single_we got %0b want 1", commit_regf_we); end
    n_cmp++; if (commit_rd_s !== 5'd5) begin n_err++; $display("FAIL single_rd got %0d want 5", commit_rd_s); end
    n_cmp++; if (commit_rd_v !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_val got %h want deadbeef", commit_rd_v); end
    n_cmp++; if (commit_rob !== 4'd0) begin n_err++; $display("FAIL single_rob got %0d want 0", commit_rob); end
    tick();
    @(negedge clk);
    n_cmp++; if (rob_empty !== 1'b1) begin n_err++; $display("FAIL single_empty got %0b want 1", rob_empty); end
    n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL single_after_cv got %0b want 0", commit_valid); end
    tick();
  endtask

  task automatic test_in_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      disp(1, 5'(i + 1));
      @(negedge clk);
      n_cmp++; if (disp_rob !== 4'(i)) begin n_err++; $display("FAIL order_tag%0d got %0d want %0d", i, disp_rob, i); end
      tick();
    end
    for (int i = 2; i >= 0; i--) begin
      clr(); cdb_valid = 1; cdb_rob = 4'(i); cdb_rd_v = 32'h100 + 32'(i);
      @(negedge clk);
      n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL order_early_cv%0d got %0b want 0", i, commit_valid); end
      tick();
    end
    clr();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL order_cv%0d got %0b want 1", i, commit_valid); end
      n_cmp++; if (commit_rob !== 4'(i)) begin n_err++; $display("FAIL order_rob%0d got %0d want %0d", i, commit_rob, i); end
      n_cmp++; if (commit_rd_v !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL order_val%0d got %h want %h", i, commit_rd_v, 32'h100 + 32'(i)); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (rob_empty !== 1'b1) begin n_err++; $display("FAIL order_empty got %0b want 1", rob_empty); end
    tick();
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      disp(1, 5'(i + 1));
      tick();
    end
    clr();
    @(negedge clk);
    n_cmp++; if (rob_full !== 1'b1) begin n_err++; $display("FAIL full_flag got %0b want 1", rob_full); end
    n_cmp++; if (disp_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %0b want 0", disp_ready); end
    n_cmp++; if (rob_count !== 5'd16) begin n_err++; $display("FAIL full_count got %0d want 16", rob_count); end
    tick();
    disp(1, 5'd20); cdb_valid = 1; cdb_rob = 0; cdb_rd_v = 32'hA0;
    tick();
    disp(1, 5'd20);
    @(negedge clk);
    n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL full_commit got %0b want 1", commit_valid); end
    n_cmp++; if (disp_ready !== 1'b0) begin n_err++; $display("FAIL full_no_bypass got %0b want 0", disp_ready); end
    tick();
    disp(1, 5'd21);
    @(negedge clk);
    n_cmp++; if (rob_count !== 5'd15) begin n_err++; $display("FAIL wrap_count_pre got %0d want 15", rob_count); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL wrap_ready got %0b want 1", disp_ready); end
    n_cmp++; if (disp_rob !== 4'd0) begin n_err++; $display("FAIL wrap_tag got %0d want 0", disp_rob); end
    tick();
    clr();
    @(negedge clk);
    n_cmp++; if (rob_count !== 5'd16) begin n_err++; $display("FAIL wrap_count got %0d want 16", rob_count); end
    n_cmp++; if (rob_full !== 1'b1) begin n_err++; $display("FAIL wrap_full got %0b want 1", rob_full); end
    n_cmp++; if (commit_rob !== 4'd1) begin n_err++; $display("FAIL wrap_head got %0d want 1", commit_rob); end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      disp(1, 5'(i + 1));
      tick();
    end
    clr(); cdb_valid = 1; cdb_rob = 0; cdb_rd_v = 32'h50;
    tick();
    disp(1, 5'd4); cdb_valid = 1; cdb_rob = 2; cdb_rd_v = 32'h52;
    @(negedge clk);
    n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL sim_cv got %0b want 1", commit_valid); end
    n_cmp++; if (disp_rob !== 4'd3) begin n_err++; $display("FAIL sim_tag got %0d want 3", disp_rob); end
    tick();
    clr(); cdb_valid = 1; cdb_rob = 1; cdb_rd_v = 32'h51;
    @(negedge clk);
    n_cmp++; if (rob_count !== 5'd3) begin n_err++; $display("FAIL sim_count got %0d want 3", rob_count); end
    tick();
    clr();
    @(negedge clk);
    n_cmp++; if (commit_rob !== 4'd1 || commit_rd_v !== 32'h51 || commit_valid !== 1'b1)
      begin n_err++; $display("FAIL sim_c1 got rob%0d v%h cv%0b want rob1 v51 cv1", commit_rob, commit_rd_v, commit_valid); end
    tick();
    @(negedge clk);
    n_cmp++; if (commit_rob !== 4'd2 || commit_rd_v !== 32'h52 || commit_valid !== 1'b1)
      begin n_err++; $display("FAIL sim_c2 got rob%0d v%h cv%0b want rob2 v52 cv1", commit_rob, commit_rd_v, commit_valid); end
    tick();
    @(negedge clk);
    n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL sim_new_not_done got %0b want 0", commit_valid); end
    n_cmp++; if (rob_count !== 5'd1) begin n_err++; $display("FAIL sim_new_valid got %0d want 1", rob_count); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      disp(1, 5'(i + 1));
      tick();
    end
    clr(); cdb_valid = 1; cdb_rob = 0; cdb_rd_v = 32'h60;
    tick();
    disp(1, 5'd9); flush = 1;
    @(negedge clk);
    n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL flush_cv got %0b want 0", commit_valid); end
    n_cmp++; if (commit_regf_we !== 1'b0) begin n_err++; $display("FAIL flush_we got %0b want 0", commit_regf_we); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %0b want 1", disp_ready); end
    tick();
    clr();
    @(negedge clk);
    n_cmp++; if (rob_empty !== 1'b1) begin n_err++; $display("FAIL flush_empty got %0b want 1", rob_empty); end
    n_cmp++; if (disp_rob !== 4'd0) begin n_err++; $display("FAIL flush_tag got %0d want 0", disp_rob); end
    tick();
    disp(1, 5'd7); cdb_valid = 1; cdb_rob = 1; cdb_rd_v = 32'hBAD;
    tick();
    clr(); cdb_valid = 1; cdb_rob = 1; cdb_rd_v = 32'hBAD;
    @(negedge clk);
    n_cmp++; if (rob_count !== 5'd1) begin n_err++; $display("FAIL late_cdb_count got %0d want 1", rob_count); end
    n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL late_cdb_cv got %0b want 0", commit_valid); end
    tick();
    clr(); cdb_valid = 1; cdb_rob = 0; cdb_rd_v = 32'h77;
    tick();
    clr();
    @(negedge clk);
    n_cmp++; if (commit_valid !== 1'b1 || commit_rd_v !== 32'h77 || commit_rd_s !== 5'd7)
      begin n_err++; $display("FAIL post_flush_commit got cv%0b v%h rd%0d want cv1 v77 rd7", commit_valid, commit_rd_v, commit_rd_s); end
    tick();
    @(negedge clk);
    n_cmp++; if (rob_count !== 5'd0) begin n_err++; $display("FAIL late_cdb_ghost got %0d want 0", rob_count); end
    tick();
  endtask

  task automatic test_x0_and_store();
    do_reset();
    disp(1, 5'd0);
    tick();
    disp(0, 5'd9);
    tick();
    clr(); cdb_valid = 1; cdb_rob = 0; cdb_rd_v = 32'h11;
    tick();
    clr(); cdb_valid = 1; cdb_rob = 1; cdb_rd_v = 32'h22;
    @(negedge clk);
    n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL x0_cv got %0b want 1", commit_valid); end
    n_cmp++; if (commit_regf_we !== 1'b0) begin n_err++; $display("FAIL x0_we got %0b want 0", commit_regf_we); end
    tick();
    clr();
    @(negedge clk);
    n_cmp++; if (commit_valid !== 1'b1 || commit_rob !== 4'd1)
      begin n_err++; $display("FAIL store_cv got cv%0b rob%0d want cv1 rob1", commit_valid, commit_rob); end
    n_cmp++; if (commit_regf_we !== 1'b0) begin n_err++; $display("FAIL store_we got %0b want 0", commit_regf_we); end
    tick();
  endtask

  initial begin
    rst = 1;
    clr();
    test_reset();
    test_single();
    test_in_order();
    test_full_wrap();
    test_simultaneous();
    test_flush();
    test_x0_and_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
